mult_sequencer: RTL and testbench

Multi-cycle control unit for the radix-4 Booth multiplier datapath. It accepts a multiply request from the processor pipeline and captures and holds both operands. It sequences the datapath through one load cycle and a fixed number of iteration cycles. It then registers the 32-bit result and an overflow exception, and reports completion with a one-cycle ready pulse. It sits between the pipeline's multdiv stall logic and the `booth` datapath, and owns all of that datapath's control inputs.

---
 rtl/mult_sequencer.sv | 148 ++++++++++++++
 tb/tb_mult_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mult_sequencer
// Description : Multi-cycle control unit for the radix-4 Booth multiplier
//               datapath. Captures and holds the operands of a multiply
//               request, strobes the datapath through one load cycle and
//               ITERS iteration cycles, then registers the low product word
//               and a signed-overflow flag and pulses data_resultRDY.
//               A zero operand (FAST_ZERO=1) skips the datapath entirely.
//
// Ports       : clock              - rising-edge clock
//               reset_n            - asynchronous active-low reset
//               ctrl_MULT          - request strobe, operands sampled with it
//               data_operandA/B    - multiplicand / multiplier (signed)
//               booth_product      - full product from the datapath
//               booth_load/step    - datapath load / iteration strobes
//               booth_multiplicand - held operand A
//               booth_multiplier   - held operand B
//               busy               - high while an operation is in flight
//               data_result        - registered product[W-1:0]
//               data_exception     - registered signed-overflow flag
//               data_resultRDY     - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mult_sequencer #(
  parameter int ITERS     = 16,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 ctrl_MULT,
  input  logic [2*ITERS-1:0]   data_operandA,
  input  logic [2*ITERS-1:0]   data_operandB,
  input  logic [4*ITERS-1:0]   booth_product,
  output logic                 booth_load,
  output logic                 booth_step,
  output logic [2*ITERS-1:0]   booth_multiplicand,
  output logic [2*ITERS-1:0]   booth_multiplier,
  output logic                 busy,
  output logic [2*ITERS-1:0]   data_result,
  output logic                 data_exception,
  output logic                 data_resultRDY
);

  localparam int c_W  = 2 * ITERS;
  localparam int c_CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic            r_zero;
  logic            r_load;
  logic            r_step;
  logic            r_busy;
  logic            r_rdy;
  logic            r_exc;
  logic [c_W-1:0]  r_mcand;
  logic [c_W-1:0]  r_mplier;
  logic [c_W-1:0]  r_result;

  logic            w_zero_op;
  logic            w_ovf;

  assign w_zero_op = FAST_ZERO && ((data_operandA == '0) || (data_operandB == '0));

  // The product fits in c_W signed bits only when the upper half is a pure
  // sign extension of bit c_W-1.
  assign w_ovf = (booth_product[2*c_W-1:c_W] != {c_W{booth_product[c_W-1]}});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_zero   <= 1'b0;
      r_load   <= 1'b0;
      r_step   <= 1'b0;
      r_busy   <= 1'b0;
      r_rdy    <= 1'b0;
      r_exc    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_result <= '0;
    end else begin
      // Strobes are asserted only for the state being entered.
      r_load <= 1'b0;
      r_rdy  <= 1'b0;

      if (ctrl_MULT) begin
        // A request in any state (re)starts the sequence; an operation in
        // flight is simply dropped without touching the result registers.
        r_mcand  <= data_operandA;
        r_mplier <= data_operandB;
        r_busy   <= 1'b1;
        r_step   <= 1'b0;
        r_zero   <= w_zero_op;
        if (w_zero_op) begin
          r_state <= S_DONE;
        end else begin
          r_state <= S_LOAD;
          r_load  <= 1'b1;
        end
      end else begin
        case (r_state)
          S_LOAD: begin
            r_cnt   <= '0;
            r_step  <= 1'b1;
            r_state <= S_RUN;
          end
          S_RUN: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
              r_step  <= 1'b0;
              r_state <= S_DONE;
            end
          end
          S_DONE: begin
            r_result <= r_zero ? '0 : booth_product[c_W-1:0];
            r_exc    <= r_zero ? 1'b0 : w_ovf;
            r_rdy    <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign booth_load         = r_load;
  assign booth_step         = r_step;
  assign booth_multiplicand = r_mcand;
  assign booth_multiplier   = r_mplier;
  assign busy               = r_busy;
  assign data_result        = r_result;
  assign data_exception     = r_exc;
  assign data_resultRDY     = r_rdy;

endmodule
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_sequencer
// Description : Self-checking bench for mult_sequencer. A behavioural Booth
//               datapath stand-in only presents the true product after one
//               load followed by exactly 16 steps. Requests push expected
//               results (signed 64-bit arithmetic) into a queue; a monitor
//               pops and compares on every ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_sequencer;

  localparam int c_ITERS = 16;

  logic        clock;
  logic        reset_n;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [63:0] booth_product;
  logic        booth_load;
  logic        booth_step;
  logic [31:0] booth_multiplicand;
  logic [31:0] booth_multiplier;
  logic        busy;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  mult_sequencer #(.ITERS(c_ITERS), .FAST_ZERO(1'b1)) u_dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .ctrl_MULT          (ctrl_MULT),
    .data_operandA      (data_operandA),
    .data_operandB      (data_operandB),
    .booth_product      (booth_product),
    .booth_load         (booth_load),
    .booth_step         (booth_step),
    .booth_multiplicand (booth_multiplicand),
    .booth_multiplier   (booth_multiplier),
    .busy               (busy),
    .data_result        (data_result),
    .data_exception     (data_exception),
    .data_resultRDY     (data_resultRDY)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- datapath stand-in ----------------
  int          dp_steps = 99;
  logic [63:0] dp_prod  = '0;
  always @(posedge clock) begin
    if (booth_load) begin
      dp_steps <= 0;
      dp_prod  <= 64'(longint'($signed(booth_multiplicand)) * longint'($signed(booth_multiplier)));
    end else if (booth_step) begin
      dp_steps <= dp_steps + 1;
    end
  end
  assign booth_product = (dp_steps == c_ITERS) ? dp_prod : 64'h5A5A_0F0F_C3C3_9696;

  // ---------------- bookkeeping ----------------
  int cyc  = 0;
  int lcnt = 0;
  int scnt = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ctrl_MULT) begin
      lcnt <= 0;
      scnt <= 0;
    end else begin
      lcnt <= lcnt + int'(booth_load);
      scnt <= scnt + int'(booth_step);
    end
  end

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          rdy;
    bit          zero;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] hold_res = '0;
  logic        hold_exc = 1'b0;
  int          bs = 0;
  int          be = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: full signed product, low word kept, overflow when the product
  // does not fit a signed 32-bit value.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int e);
    exp_t   r;
    longint p;
    p      = longint'($signed(a)) * longint'($signed(b));
    r.zero = (a == 0) || (b == 0);
    r.res  = p[31:0];
    r.exc  = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    r.rdy  = r.zero ? e + 1 : e + c_ITERS + 2;
    return r;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      chk("load_step_exclusive", {booth_load, booth_step} == 2'b11, 0);
      chk("busy", busy, (cyc >= bs) && (cyc < be));
      if (q.size() > 0 && (data_resultRDY || cyc >= q[0].rdy)) begin
        e = q.pop_front();
        chk("rdy_pulse", data_resultRDY, 1);
        chk("rdy_cycle", cyc, e.rdy);
        if (data_resultRDY) begin
          chk("result", data_result, e.res);
          chk("exception", data_exception, e.exc);
          chk("load_count", lcnt, e.zero ? 0 : 1);
          chk("step_count", scnt, e.zero ? 0 : c_ITERS);
        end
        hold_res = e.res;
        hold_exc = e.exc;
      end else if (data_resultRDY) begin
        chk("unexpected_rdy", 1, 0);
      end
      chk("result_hold", data_result, hold_res);
      chk("exception_hold", data_exception, hold_exc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic req(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   edge_e;
    @(negedge clock);
    edge_e = cyc + 1;
    if (q.size() > 0 && edge_e <= q[$].rdy) begin
      void'(q.pop_back());   // aborted: no pulse expected
    end else begin
      bs = edge_e;
    end
    e  = model(a, b, edge_e);
    be = e.rdy;
    q.push_back(e);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;   // must be ignored
    data_operandB = $urandom;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_load"}, booth_load, 0);
    chk({tag, "_step"}, booth_step, 0);
    chk({tag, "_rdy"}, data_resultRDY, 0);
    chk({tag, "_exc"}, data_exception, 0);
    chk({tag, "_result"}, data_result, 0);
    chk({tag, "_mcand"}, booth_multiplicand, 0);
    chk({tag, "_mplier"}, booth_multiplier, 0);
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!data_resultRDY && n < 40) begin
      @(posedge clock);
      #2;
      n++;
    end
    chk("wait_rdy_timeout", n >= 40, 0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          gap;
    int          n;
    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #2;
    chk_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Basic, overflow and fast-zero cases.
    req(32'd7, 32'hFFFF_FFFD);
    repeat (22) @(negedge clock);
    req(32'h0001_0000, 32'h0001_0000);
    repeat (22) @(negedge clock);
    req(32'h8000_0000, 32'hFFFF_FFFF);
    repeat (22) @(negedge clock);
    req(32'd0, 32'h1234_5678);
    repeat (4) @(negedge clock);

    // Restart during RUN: only the second operation completes.
    req(32'd5, 32'd6);
    repeat (7) @(negedge clock);
    req(32'd3, 32'd4);
    repeat (22) @(negedge clock);

    // Asynchronous reset in the middle of RUN.
    req(32'd11, 32'd13);
    repeat (5) @(posedge clock);
    #3;
    reset_n = 1'b0;
    q.delete();
    bs = 0;
    be = 0;
    hold_res = '0;
    hold_exc = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    req(32'd2, 32'd2);
    repeat (22) @(negedge clock);

    // Back-to-back: second request issued in the ready cycle of the first.
    req(32'd9, 32'd9);
    wait_rdy();
    req(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (22) @(negedge clock);

    // Randomized requests with random gaps (restarts and zeros included).
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 3) == 0) a = 32'($signed(16'($urandom)));
      req(a, b);
      gap = $urandom_range(0, 24);
      repeat (gap) @(negedge clock);
    end

    n = 0;
    while (q.size() > 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("drain", q.size(), 0);
    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
